// File: rtl/fp_arb_pkg.sv
// Shared types and constants for the fp_add_arbiter slice.
// The optional adder watchdog is enabled by defining FP_ARB_TIMEOUT_EN.
package fp_arb_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_START,
        S_WAIT_LO,
        S_WAIT_HI,
        S_RESP
    } state_t;

    localparam int W_DEFAULT = 32;

    localparam logic [31:0] QNAN = 32'h7FC00000;

    // Pointer starts at the last requester so that requester 0 wins the first round.
    function automatic int reset_ptr(input int nreq);
        return nreq - 1;
    endfunction

endpackage

// File: rtl/fp_add_arbiter_if.sv
// Requester, response and adder-side signals of fp_add_arbiter.
// slave is the arbiter's view; master is the environment driving it.
interface fp_add_arbiter_if
    import fp_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = W_DEFAULT
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] a_in;
    logic [NREQ*W-1:0] b_in;
    logic [NREQ-1:0]   gnt;
    logic              busy;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_result;
    logic              rsp_err;
    logic              add_start;
    logic [W-1:0]      add_A;
    logic [W-1:0]      add_B;
    logic              add_done;
    logic [W-1:0]      add_R;
    logic              add_rst;

    modport slave (
        input  req, a_in, b_in, rsp_ready, add_done, add_R,
        output gnt, busy, rsp_valid, rsp_id, rsp_result, rsp_err,
               add_start, add_A, add_B, add_rst
    );

    modport master (
        output req, a_in, b_in, rsp_ready, add_done, add_R,
        input  gnt, busy, rsp_valid, rsp_id, rsp_result, rsp_err,
               add_start, add_A, add_B, add_rst
    );

endinterface

// File: rtl/fp_rr_picker.sv
// Combinational round-robin picker: first set req bit searching upward
// from ptr+1 (wrapping), so the last-served requester has lowest priority.
module fp_rr_picker
    import fp_arb_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] pick,
    output logic [IDW-1:0]  idx,
    output logic            any_req
);

    logic found;
    int   cand;

    always_comb begin
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(ptr) + k) % NREQ;
            if (!found && req[cand]) begin
                found      = 1'b1;
                pick[cand] = 1'b1;
                idx        = IDW'(cand);
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/fp_add_arbiter.sv
// Shares one start/done floating-point adder between NREQ requesters with
// round-robin arbitration; optional watchdog under FP_ARB_TIMEOUT_EN.
module fp_add_arbiter
    import fp_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int W       = W_DEFAULT,
    parameter int TIMEOUT = 255
) (
    input  logic            CLK,
    input  logic            rst,
    fp_add_arbiter_if.slave bus
);

    localparam int IDW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_cfg
        $error("fp_add_arbiter: NREQ or TIMEOUT out of range");
    end

    state_t          state;
    state_t          next_state;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  sel;
    logic [IDW-1:0]  pick_idx;
    logic [NREQ-1:0] pick_oh;
    logic [NREQ-1:0] sel_oh;
    logic            any_req;
    logic            done_capture;
    logic            timeout_hit;
    logic [W-1:0]    add_a_q;
    logic [W-1:0]    add_b_q;
    logic [W-1:0]    rsp_result_q;
    logic [IDW-1:0]  rsp_id_q;

    fp_rr_picker #(.NREQ(NREQ)) u_picker (
        .req     (bus.req),
        .ptr     (ptr),
        .pick    (pick_oh),
        .idx     (pick_idx),
        .any_req (any_req)
    );

    assign done_capture = (state == S_WAIT_HI) && bus.add_done;

`ifdef FP_ARB_TIMEOUT_EN
    logic [7:0] watchdog;
    logic       add_rst_q;
    logic       rsp_err_q;

    // A normal completion in the same cycle as expiry wins over the timeout.
    assign timeout_hit = ((state == S_WAIT_LO) || (state == S_WAIT_HI)) &&
                         !done_capture && (watchdog == 8'(TIMEOUT - 1));

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            watchdog  <= '0;
            add_rst_q <= 1'b0;
            rsp_err_q <= 1'b0;
        end else begin
            add_rst_q <= timeout_hit;
            if (state == S_GRANT)
                watchdog <= '0;
            else if ((state == S_WAIT_LO) || (state == S_WAIT_HI))
                watchdog <= watchdog + 8'd1;
            if (timeout_hit)
                rsp_err_q <= 1'b1;
            else if (done_capture)
                rsp_err_q <= 1'b0;
        end
    end

    assign bus.add_rst = add_rst_q;
    assign bus.rsp_err = rsp_err_q;
`else
    assign timeout_hit = 1'b0;
    assign bus.add_rst = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    always_ff @(posedge CLK or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:    if (any_req) next_state = S_GRANT;
            S_GRANT:   next_state = S_START;
            S_START:   next_state = S_WAIT_LO;
            S_WAIT_LO: begin
                if (timeout_hit)
                    next_state = S_RESP;
                else if (!bus.add_done)
                    next_state = S_WAIT_HI;
            end
            S_WAIT_HI: if (done_capture || timeout_hit) next_state = S_RESP;
            S_RESP:    if (bus.rsp_ready) next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    // Selection is frozen in IDLE so a requester dropping req later cannot disturb it.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            sel          <= '0;
            sel_oh       <= '0;
            ptr          <= IDW'(reset_ptr(NREQ));
            add_a_q      <= '0;
            add_b_q      <= '0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
        end else begin
            if ((state == S_IDLE) && any_req) begin
                sel    <= pick_idx;
                sel_oh <= pick_oh;
            end
            if (state == S_GRANT) begin
                ptr     <= sel;
                add_a_q <= bus.a_in[int'(sel)*W +: W];
                add_b_q <= bus.b_in[int'(sel)*W +: W];
            end
            if (done_capture) begin
                rsp_result_q <= bus.add_R;
                rsp_id_q     <= sel;
            end else if (timeout_hit) begin
                rsp_result_q <= W'(QNAN);
                rsp_id_q     <= sel;
            end
        end
    end

    assign bus.gnt        = (state == S_GRANT) ? sel_oh : '0;
    assign bus.busy       = (state != S_IDLE);
    assign bus.add_start  = (state == S_START);
    assign bus.rsp_valid  = (state == S_RESP);
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.add_A      = add_a_q;
    assign bus.add_B      = add_b_q;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench for fp_add_arbiter with a behavioural adder and a response scoreboard.
// Watchdog steps are included when FP_ARB_TIMEOUT_EN is defined.
module tb_fp_add_arbiter;
    import fp_arb_pkg::*;

    localparam int NREQ    = 4;
    localparam int W       = 32;
    localparam int TIMEOUT = 20;

    logic CLK;
    logic rst;

    fp_add_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

    fp_add_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .CLK (CLK),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [1:0]  id;
        logic [31:0] result;
        logic        err;
    } exp_t;

    exp_t        sbQ[$];
    int          testCount = 0;
    int          failCount = 0;
    int          adderLat  = 10;
    logic        adderHang = 1'b0;
    int          mCnt;
    logic [31:0] mRes;

    logic [31:0] opA [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    logic [31:0] opB [4] = '{32'h3F000000, 32'h3F800000, 32'h40000000, 32'h40A00000};
    logic [31:0] sums[4] = '{32'h3FC00000, 32'h40400000, 32'h40A00000, 32'h41100000};
    int          order[5] = '{0, 1, 2, 3, 0};

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global time limit reached");
        $fatal(1, "[TB] simulation hung");
    end

    // Normal-number single<->double conversion, enough for the exact sums used here.
    function automatic real spToReal(input logic [31:0] s);
        logic [63:0] d;
        logic [10:0] e;
        if (s[30:0] == 31'd0) begin
            d = {s[31], 63'd0};
        end else begin
            e = 11'(s[30:23]) + 11'd896;
            d = {s[31], e, s[22:0], 29'd0};
        end
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] realToSp(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] expSum(input logic [31:0] a, input logic [31:0] b);
        return realToSp(spToReal(a) + spToReal(b));
    endfunction

    // Adder model: done idles high, drops after start, rises again after adderLat cycles.
    always @(posedge CLK or posedge rst) begin
        if (rst) begin
            bus.add_done <= 1'b1;
            bus.add_R    <= '0;
            mCnt         <= 0;
        end else if (bus.add_rst) begin
            bus.add_done <= 1'b1;
            mCnt         <= 0;
        end else if (bus.add_done) begin
            if (bus.add_start) begin
                bus.add_done <= 1'b0;
                mCnt         <= adderLat;
                mRes         <= expSum(bus.add_A, bus.add_B);
            end
        end else if (!adderHang) begin
            if (mCnt <= 1) begin
                bus.add_done <= 1'b1;
                bus.add_R    <= mRes;
            end else begin
                mCnt <= mCnt - 1;
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] reqMask);
        bus.req = reqMask;
    endtask

    task automatic setOperands(input int i, input logic [31:0] a, input logic [31:0] b);
        bus.a_in[i*W +: W] = a;
        bus.b_in[i*W +: W] = b;
    endtask

    task automatic expectRsp(input int id, input logic [31:0] result, input logic err);
        exp_t e;
        e.id     = 2'(id);
        e.result = result;
        e.err    = err;
        sbQ.push_back(e);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, " gnt"},        32'(bus.gnt),        32'd0);
        checkOutput({tag, " busy"},       32'(bus.busy),       32'd0);
        checkOutput({tag, " rsp_valid"},  32'(bus.rsp_valid),  32'd0);
        checkOutput({tag, " rsp_id"},     32'(bus.rsp_id),     32'd0);
        checkOutput({tag, " rsp_result"}, bus.rsp_result,      32'd0);
        checkOutput({tag, " rsp_err"},    32'(bus.rsp_err),    32'd0);
        checkOutput({tag, " add_start"},  32'(bus.add_start),  32'd0);
        checkOutput({tag, " add_A"},      bus.add_A,           32'd0);
        checkOutput({tag, " add_B"},      bus.add_B,           32'd0);
        checkOutput({tag, " add_rst"},    32'(bus.add_rst),    32'd0);
    endtask

    task automatic waitGrant(input string tag, input logic [3:0] expGnt);
        for (int n = 0; n < 50 && bus.gnt == '0; n++) tick();
        checkOutput(tag, 32'(bus.gnt), 32'(expGnt));
    endtask

    // Waits for a response, compares it against the scoreboard head, then
    // takes the acceptance edge when rsp_ready is high (ending in IDLE).
    task automatic waitResponse(input string tag);
        exp_t e;
        for (int n = 0; n < 200 && !bus.rsp_valid; n++) tick();
        checkOutput({tag, " valid"}, 32'(bus.rsp_valid), 32'd1);
        if (sbQ.size() == 0) begin
            checkOutput({tag, " scoreboard depth"}, 32'(sbQ.size()), 32'd1);
            return;
        end
        e = sbQ.pop_front();
        checkOutput({tag, " id"},     32'(bus.rsp_id),  32'(e.id));
        checkOutput({tag, " result"}, bus.rsp_result,   e.result);
        checkOutput({tag, " err"},    32'(bus.rsp_err), 32'(e.err));
        if (bus.rsp_ready) tick();
    endtask

    initial begin
        rst           = 1'b1;
        bus.req       = '0;
        bus.a_in      = '0;
        bus.b_in      = '0;
        bus.rsp_ready = 1'b1;
        tick();
        tick();
        checkReset("reset");
        rst = 1'b0;
        tick();

        // Single request from requester 2: 1.0 + 2.0
        setOperands(2, 32'h3F800000, 32'h40000000);
        expectRsp(2, 32'h40400000, 1'b0);
        applyStimulus(4'b0100);
        waitGrant("t1 gnt", 4'b0100);
        applyStimulus(4'b0000);
        tick();
        checkOutput("t1 gnt one cycle", 32'(bus.gnt), 32'd0);
        checkOutput("t1 add_start", 32'(bus.add_start), 32'd1);
        checkOutput("t1 add_A", bus.add_A, 32'h3F800000);
        checkOutput("t1 add_B", bus.add_B, 32'h40000000);
        tick();
        checkOutput("t1 add_start pulse", 32'(bus.add_start), 32'd0);
        checkOutput("t1 busy", 32'(bus.busy), 32'd1);
        waitResponse("t1 rsp");
        checkOutput("t1 idle busy", 32'(bus.busy), 32'd0);
        checkOutput("t1 add_rst", 32'(bus.add_rst), 32'd0);

        // All four requesting continuously from a fresh pointer
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) setOperands(i, opA[i], opB[i]);
        tick();
        applyStimulus(4'b1111);
        for (int k = 0; k < 5; k++) begin
            expectRsp(order[k], sums[order[k]], 1'b0);
            waitGrant($sformatf("t2 gnt %0d", k), 4'(1 << order[k]));
            if (k == 4) applyStimulus(4'b0000);
            waitResponse($sformatf("t2 rsp %0d", k));
        end
        checkOutput("t2 drained busy", 32'(bus.busy), 32'd0);

        // Backpressure on requester 1; requester 0 queues behind it
        bus.rsp_ready = 1'b0;
        expectRsp(1, 32'h40400000, 1'b0);
        applyStimulus(4'b0010);
        waitGrant("t3 gnt", 4'b0010);
        applyStimulus(4'b0000);
        waitResponse("t3 rsp");
        applyStimulus(4'b0001);
        for (int k = 0; k < 5; k++) begin
            tick();
            checkOutput($sformatf("t3 hold valid %0d", k), 32'(bus.rsp_valid), 32'd1);
            checkOutput($sformatf("t3 hold result %0d", k), bus.rsp_result, 32'h40400000);
            checkOutput($sformatf("t3 hold id %0d", k), 32'(bus.rsp_id), 32'd1);
            checkOutput($sformatf("t3 no gnt %0d", k), 32'(bus.gnt), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        expectRsp(0, 32'h3FC00000, 1'b0);
        tick();
        checkOutput("t3 idle after accept", 32'(bus.gnt), 32'd0);
        tick();
        checkOutput("t3 queued gnt", 32'(bus.gnt), 32'd1);
        applyStimulus(4'b0000);
        waitResponse("t3 rsp2");

        // Requests arrive while requester 1 is in WAIT_HI
        expectRsp(1, 32'h40400000, 1'b0);
        applyStimulus(4'b0010);
        waitGrant("t4 gnt", 4'b0010);
        applyStimulus(4'b0000);
        tick();
        tick();
        tick();
        checkOutput("t4 adder running", 32'(bus.add_done), 32'd0);
        applyStimulus(4'b1001);
        expectRsp(3, 32'h41100000, 1'b0);
        expectRsp(0, 32'h3FC00000, 1'b0);
        waitResponse("t4 rsp1");
        checkOutput("t4 idle gap", 32'(bus.gnt), 32'd0);
        tick();
        checkOutput("t4 immediate gnt", 32'(bus.gnt), 32'b1000);
        applyStimulus(4'b0001);
        waitResponse("t4 rsp3");
        tick();
        checkOutput("t4 then gnt0", 32'(bus.gnt), 32'd1);
        applyStimulus(4'b0000);
        waitResponse("t4 rsp0");

        // Reset while requester 2 sits in WAIT_HI
        applyStimulus(4'b0100);
        waitGrant("t5 gnt", 4'b0100);
        applyStimulus(4'b0000);
        tick();
        tick();
        tick();
        checkOutput("t5 busy before reset", 32'(bus.busy), 32'd1);
        #1 rst = 1'b1;
        #1 checkReset("t5 async");
        tick();
        checkReset("t5 next cycle");
        rst = 1'b0;
        expectRsp(0, 32'h3FC00000, 1'b0);
        expectRsp(2, 32'h40A00000, 1'b0);
        applyStimulus(4'b0101);
        waitGrant("t5 first after reset", 4'b0001);
        applyStimulus(4'b0100);
        waitResponse("t5 rsp0");
        waitGrant("t5 second", 4'b0100);
        applyStimulus(4'b0000);
        waitResponse("t5 rsp2");
        checkOutput("t5 scoreboard drained", 32'(sbQ.size()), 32'd0);

`ifdef FP_ARB_TIMEOUT_EN
        // Adder never completes: watchdog fires after TIMEOUT wait cycles
        adderHang = 1'b1;
        expectRsp(1, 32'h7FC00000, 1'b1);
        applyStimulus(4'b0010);
        waitGrant("t6 gnt", 4'b0010);
        applyStimulus(4'b0000);
        tick();
        for (int k = 1; k <= TIMEOUT; k++) begin
            tick();
            if (k == TIMEOUT) begin
                checkOutput("t6 no early valid", 32'(bus.rsp_valid), 32'd0);
                checkOutput("t6 no early add_rst", 32'(bus.add_rst), 32'd0);
            end
        end
        tick();
        checkOutput("t6 add_rst pulse", 32'(bus.add_rst), 32'd1);
        waitResponse("t6 rsp");
        checkOutput("t6 add_rst cleared", 32'(bus.add_rst), 32'd0);
        adderHang = 1'b0;
        expectRsp(2, 32'h40A00000, 1'b0);
        applyStimulus(4'b0100);
        waitGrant("t6 recover gnt", 4'b0100);
        applyStimulus(4'b0000);
        waitResponse("t6 recover rsp");
`endif

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
